// File: rtl/axi_frame_pkg.sv
//------------------------------------------------------------------------------
// axi_frame_pkg : shared FSM encoding and AXI read-channel constants
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axi_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_NEXT = 2'd3
    } rd_state_e;

    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_DEF  = 4'b0011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int BYTES_PER_PIXEL = 4;
    localparam int BYTES_PER_BEAT  = 8;
    localparam int PIXEL_W         = 24;

endpackage

`default_nettype wire

// File: rtl/frame_beat_fifo.sv
//------------------------------------------------------------------------------
// frame_beat_fifo : first-word-fall-through beat FIFO with count/free outputs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module frame_beat_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic [DATA_W-1:0]      pop_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] free_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              w_push;
    logic              w_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign free_o     = CNT_W'(DEPTH) - count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO may still accept a push
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_frame_reader.sv
//------------------------------------------------------------------------------
// axi_frame_reader : AXI3 burst reader that streams a frame as 24-bit pixels
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_frame_reader
    import axi_frame_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 64,
    parameter int          FRAME_W    = 1920,
    parameter int          FRAME_H    = 1080,
    parameter logic [31:0] ADDR_START = 32'h1000_0000,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [3:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [23:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              frame_done,
    output logic              rd_err
);

    localparam int BEATS_PER_FRAME  = FRAME_W * FRAME_H / 2;
    localparam int BURSTS_PER_FRAME = BEATS_PER_FRAME / BURST_LEN;
    localparam int BURST_W          = $clog2(BURSTS_PER_FRAME + 1);
    localparam int CNT_W            = $clog2(FIFO_DEPTH) + 1;
    localparam int COL_W            = $clog2(FRAME_W + 1);
    localparam int LINE_W           = $clog2(FRAME_H + 1);
    localparam int SLOT_W           = BYTES_PER_PIXEL * 8;

    rd_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [3:0]          beat_q, beat_d;
    logic                err_q, err_d;

    logic                half_q;
    logic [COL_W-1:0]    col_q;
    logic [LINE_W-1:0]   line_q;
    logic                frame_done_q;

    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_full;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W-1:0]    w_free;
    logic [DATA_W-1:0]   w_beat;
    logic                w_room;
    logic                w_last_beat;
    logic                w_last_burst;
    logic                w_accept;
    logic                w_col_last;
    logic                w_line_last;
    logic                w_unused;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 4'(BURST_LEN - 1);
    assign m_axi_arsize  = SIZE_8B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arcache = CACHE_DEF;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arqos   = 4'b0000;
    assign rd_err        = err_q;

    assign w_room       = (w_free >= CNT_W'(BURST_LEN));
    assign w_last_beat  = (beat_q == 4'(BURST_LEN - 1));
    assign w_last_burst = (burst_q == BURST_W'(BURSTS_PER_FRAME - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_W'(ADDR_START);
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        burst_d       = burst_q;
        beat_d        = beat_q;
        err_d         = err_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        w_push        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && w_room) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Room for the whole burst was reserved before the AR was issued
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    w_push = 1'b1;
                    beat_d = beat_q + 4'd1;
                    if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != w_last_beat)) begin
                        err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        beat_d  = '0;
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (w_last_burst) begin
                    addr_d  = ADDR_W'(ADDR_START);
                    burst_d = '0;
                    state_d = ST_IDLE;
                end else if (w_room) begin
                    addr_d  = addr_q + ADDR_W'(BURST_LEN * BYTES_PER_BEAT);
                    burst_d = burst_q + BURST_W'(1);
                    state_d = ST_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    frame_beat_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .push_i      (w_push),
        .push_data_i (m_axi_rdata),
        .pop_i       (w_pop),
        .pop_data_o  (w_beat),
        .empty_o     (w_empty),
        .full_o      (w_full),
        .count_o     (w_count),
        .free_o      (w_free)
    );

    assign w_unused = ^{w_full, w_count, w_beat[SLOT_W-1:PIXEL_W], w_beat[DATA_W-1:SLOT_W+PIXEL_W]};

    assign pix_valid   = !w_empty;
    assign w_accept    = pix_valid && pix_ready;
    assign w_pop       = w_accept && half_q;
    assign w_col_last  = (col_q == COL_W'(FRAME_W - 1));
    assign w_line_last = (line_q == LINE_W'(FRAME_H - 1));
    assign pix_data    = half_q ? w_beat[SLOT_W +: PIXEL_W] : w_beat[0 +: PIXEL_W];
    assign pix_sof     = pix_valid && (col_q == '0) && (line_q == '0);
    assign pix_eol     = pix_valid && w_col_last;
    assign frame_done  = frame_done_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            half_q       <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= w_accept && w_col_last && w_line_last;
            if (w_accept) begin
                half_q <= ~half_q;
                if (w_col_last) begin
                    col_q  <= '0;
                    line_q <= w_line_last ? '0 : line_q + LINE_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_frame_reader.sv
//------------------------------------------------------------------------------
// tb_axi_frame_reader : directed bench with a small AXI read-slave model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_frame_reader;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] m_axi_araddr;
    logic [3:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;
    logic        rd_err;

    int n_checks = 0;
    int n_pass   = 0;

    int ar_delay       = 0;
    int err_resp_beat  = -1;
    int err_rlast_beat = -1;
    int ar_wait = 0, pend = 0, bib = 0, beat_n = 0;
    bit ar_hs_n = 0, r_hs_n = 0;

    logic [31:0] ar_addr_q[$];
    logic [3:0]  ar_len_q[$];
    int          ar_rb_q[$];
    logic [23:0] pix_q[$];
    bit          sof_q[$];
    bit          eol_q[$];
    int          r_cnt  = 0;
    int          fd_cnt = 0;

    axi_frame_reader #(
        .FRAME_W (16),
        .FRAME_H (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .frame_done    (frame_done),
        .rd_err        (rd_err)
    );

    always #5 aclk = ~aclk;

    // Handshakes seen at the negedge are the ones completing at the next posedge
    always @(negedge aclk) begin
        ar_hs_n = m_axi_arvalid && m_axi_arready;
        r_hs_n  = m_axi_rvalid && m_axi_rready;
        if (aresetn) begin
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(m_axi_arlen);
                ar_rb_q.push_back(r_cnt);
            end
            if (m_axi_rvalid && m_axi_rready) r_cnt++;
            if (pix_valid && pix_ready) begin
                pix_q.push_back(pix_data);
                sof_q.push_back(pix_sof);
                eol_q.push_back(pix_eol);
            end
            if (frame_done) fd_cnt++;
        end
    end

    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_rresp   = 2'b00;
            ar_wait = 0; pend = 0; bib = 0; beat_n = 0;
        end else begin
            if (ar_hs_n) pend++;
            if (r_hs_n) begin
                beat_n++;
                if (bib == 15) begin
                    bib = 0;
                    pend--;
                end else begin
                    bib++;
                end
            end
            if (m_axi_arvalid) begin
                m_axi_arready = (ar_wait >= ar_delay);
                ar_wait++;
            end else begin
                m_axi_arready = 1'b0;
                ar_wait = 0;
            end
            if (pend > 0) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = {8'h00, 24'(2 * beat_n + 1), 8'h00, 24'(2 * beat_n)};
                m_axi_rlast  = (bib == 15) || (bib == err_rlast_beat);
                m_axi_rresp  = (beat_n == err_resp_beat) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        enable = 1'b0;
        pix_ready = 1'b0;
        ar_delay = 0;
        err_resp_beat = -1;
        err_rlast_beat = -1;
        ar_addr_q.delete(); ar_len_q.delete(); ar_rb_q.delete();
        pix_q.delete(); sof_q.delete(); eol_q.delete();
        r_cnt = 0;
        fd_cnt = 0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic wait_frame(input string name, input int n_ar);
        for (int i = 0; i < 3000; i++) begin
            if (ar_addr_q.size() >= n_ar && pix_q.size() >= 64) break;
            @(negedge aclk);
        end
        repeat (2) @(negedge aclk);
        n_checks++;
        if (ar_addr_q.size() < n_ar || pix_q.size() < 64)
            $display("FAIL %s_timeout ar=%0d pix=%0d required ar>=%0d pix>=64", name,
                     ar_addr_q.size(), pix_q.size(), n_ar);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({m_axi_arvalid, m_axi_rready, pix_valid, pix_sof, pix_eol, frame_done, rd_err} !== 7'b0)
            $display("FAIL reset_outputs got=%b required=0000000",
                     {m_axi_arvalid, m_axi_rready, pix_valid, pix_sof, pix_eol, frame_done, rd_err});
        else n_pass++;
        n_checks++;
        if (m_axi_araddr !== 32'h1000_0000)
            $display("FAIL reset_araddr got=%h required=10000000", m_axi_araddr);
        else n_pass++;
        n_checks++;
        if ({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache} !== {4'hF, 3'b011, 2'b01, 4'b0011})
            $display("FAIL reset_ar_const got=%h/%h/%h/%h required=f/3/1/3",
                     m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache);
        else n_pass++;
        n_checks++;
        if ({m_axi_arprot, m_axi_arlock, m_axi_arqos} !== 8'h00)
            $display("FAIL reset_prot_lock_qos got=%h required=00", {m_axi_arprot, m_axi_arlock, m_axi_arqos});
        else n_pass++;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_frame();
        do_reset();
        enable = 1'b1;
        pix_ready = 1'b1;
        wait_frame("frame", 3);
        n_checks++;
        if (ar_addr_q[0] !== 32'h1000_0000 || ar_addr_q[1] !== 32'h1000_0080 || ar_addr_q[2] !== 32'h1000_0000)
            $display("FAIL frame_addrs got=%h,%h,%h required=10000000,10000080,10000000",
                     ar_addr_q[0], ar_addr_q[1], ar_addr_q[2]);
        else n_pass++;
        n_checks++;
        if (ar_len_q[0] !== 4'hF || ar_len_q[1] !== 4'hF)
            $display("FAIL frame_arlen got=%h,%h required=f,f", ar_len_q[0], ar_len_q[1]);
        else n_pass++;
        n_checks++;
        if (ar_rb_q[1] != 16 || ar_rb_q[2] != 32)
            $display("FAIL frame_beats_before_ar got=%0d,%0d required=16,32", ar_rb_q[1], ar_rb_q[2]);
        else n_pass++;
        for (int k = 0; k < 64 && k < pix_q.size(); k++) begin
            n_checks++;
            if (pix_q[k] !== 24'(k) || sof_q[k] !== (k == 0) || eol_q[k] !== (k % 16 == 15))
                $display("FAIL frame_pixel%0d got=%h sof=%0d eol=%0d required=%h sof=%0d eol=%0d",
                         k, pix_q[k], sof_q[k], eol_q[k], 24'(k), (k == 0), (k % 16 == 15));
            else n_pass++;
        end
        n_checks++;
        if (fd_cnt != 1)
            $display("FAIL frame_done_count got=%0d required=1", fd_cnt);
        else n_pass++;
        n_checks++;
        if (rd_err !== 1'b0)
            $display("FAIL frame_rd_err got=%b required=0", rd_err);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        enable = 1'b1;
        pix_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (i % 20 == 19) begin
                n_checks++;
                if (pix_valid !== 1'b1 || pix_data !== 24'h0 || pix_sof !== 1'b1)
                    $display("FAIL bp_hold cycle=%0d got valid=%b data=%h sof=%b required 1/000000/1",
                             i, pix_valid, pix_data, pix_sof);
                else n_pass++;
            end
        end
        n_checks++;
        if (ar_addr_q.size() != 2)
            $display("FAIL bp_ar_count got=%0d required=2", ar_addr_q.size());
        else n_pass++;
        n_checks++;
        if (ar_addr_q.size() > 1 && ar_addr_q[1] !== 32'h1000_0080)
            $display("FAIL bp_second_addr got=%h required=10000080", ar_addr_q[1]);
        else n_pass++;
        n_checks++;
        if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || r_cnt != 32)
            $display("FAIL bp_stalled got arvalid=%b rready=%b beats=%0d required 0/0/32",
                     m_axi_arvalid, m_axi_rready, r_cnt);
        else n_pass++;
    endtask

    task automatic test_ar_delay();
        logic [31:0] addr0;
        do_reset();
        ar_delay = 5;
        enable = 1'b1;
        pix_ready = 1'b1;
        for (int i = 0; i < 50 && !m_axi_arvalid; i++) @(negedge aclk);
        addr0 = m_axi_araddr;
        n_checks++;
        if (m_axi_arvalid !== 1'b1 || addr0 !== 32'h1000_0000)
            $display("FAIL ardly_start got arvalid=%b addr=%h required 1/10000000", m_axi_arvalid, addr0);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (m_axi_arvalid !== 1'b1 || m_axi_arready !== 1'b0 || m_axi_araddr !== addr0 || m_axi_rready !== 1'b0)
                $display("FAIL ardly_hold%0d got arvalid=%b arready=%b addr=%h rready=%b required 1/0/%h/0",
                         c, m_axi_arvalid, m_axi_arready, m_axi_araddr, m_axi_rready, addr0);
            else n_pass++;
            @(negedge aclk);
        end
        n_checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_arready !== 1'b1 || r_cnt != 0)
            $display("FAIL ardly_handshake got arvalid=%b arready=%b beats=%0d required 1/1/0",
                     m_axi_arvalid, m_axi_arready, r_cnt);
        else n_pass++;
        wait_frame("ardly", 2);
        n_checks++;
        if (pix_q.size() > 40 && (pix_q[0] !== 24'd0 || pix_q[40] !== 24'd40))
            $display("FAIL ardly_pixels got=%h,%h required=000000,000028", pix_q[0], pix_q[40]);
        else n_pass++;
    endtask

    task automatic test_rresp_err();
        do_reset();
        err_resp_beat = 3;
        enable = 1'b1;
        pix_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (m_axi_rvalid && m_axi_rready && m_axi_rresp == 2'b10) break;
            @(negedge aclk);
        end
        n_checks++;
        if (m_axi_rresp !== 2'b10 || rd_err !== 1'b0)
            $display("FAIL rresp_before got resp=%b rd_err=%b required 10/0", m_axi_rresp, rd_err);
        else n_pass++;
        @(negedge aclk);
        n_checks++;
        if (rd_err !== 1'b1)
            $display("FAIL rresp_set got=%b required=1", rd_err);
        else n_pass++;
        wait_frame("rresp", 2);
        n_checks++;
        if (rd_err !== 1'b1 || fd_cnt != 1 || pix_q[63] !== 24'd63)
            $display("FAIL rresp_frame got rd_err=%b fd=%0d pix63=%h required 1/1/00003f",
                     rd_err, fd_cnt, pix_q[63]);
        else n_pass++;
    endtask

    task automatic test_rlast_err();
        do_reset();
        err_rlast_beat = 7;
        enable = 1'b1;
        pix_ready = 1'b1;
        wait_frame("rlast", 2);
        n_checks++;
        if (rd_err !== 1'b1)
            $display("FAIL rlast_err got=%b required=1", rd_err);
        else n_pass++;
        n_checks++;
        if (ar_rb_q[1] != 16)
            $display("FAIL rlast_beats_before_next got=%0d required=16", ar_rb_q[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        err_resp_beat = 0;
        enable = 1'b1;
        pix_ready = 1'b1;
        for (int i = 0; i < 200 && r_cnt < 20; i++) @(negedge aclk);
        n_checks++;
        if (m_axi_rready !== 1'b1 || rd_err !== 1'b1 || ar_addr_q.size() != 2)
            $display("FAIL midrst_pre got rready=%b rd_err=%b ars=%0d required 1/1/2",
                     m_axi_rready, rd_err, ar_addr_q.size());
        else n_pass++;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (m_axi_arvalid !== 1'b0 || pix_valid !== 1'b0 || rd_err !== 1'b0 || m_axi_rready !== 1'b0)
            $display("FAIL midrst_clear got arvalid=%b pix_valid=%b rd_err=%b rready=%b required 0/0/0/0",
                     m_axi_arvalid, pix_valid, rd_err, m_axi_rready);
        else n_pass++;
        do_reset();
        enable = 1'b1;
        pix_ready = 1'b1;
        for (int i = 0; i < 50 && ar_addr_q.size() == 0; i++) @(negedge aclk);
        n_checks++;
        if (ar_addr_q.size() == 0 || ar_addr_q[0] !== 32'h1000_0000)
            $display("FAIL midrst_first_ar got count=%0d addr=%h required 1 at 10000000",
                     ar_addr_q.size(), (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hx);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_ar_delay();
        test_rresp_err();
        test_rlast_err();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_frame_reader.md
Name: axi_frame_reader

Overview:
- AXI3 read-burst master that fetches a frame from the DDR frame region filled by the write traffic generator.
- Unpacks each 64-bit beat into two 24-bit RGB pixels and emits them on a valid/ready pixel stream with start-of-frame and end-of-line markers.
- Acts as the downstream consumer of the frame buffer, feeding display or checker logic.
- Holds at most one outstanding burst; a burst is issued only when the local FIFO can absorb all of it.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 64, AXI data width; fixed at 64 (2 pixels/beat)
- FRAME_W, 1920, pixels per line
- FRAME_H, 1080, lines per frame
- ADDR_START, 32'h10000000, frame base byte address
- BURST_LEN, 16, beats per burst (arlen = BURST_LEN-1)
- FIFO_DEPTH, 32, beat FIFO depth; power of 2, >= BURST_LEN

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  start/continue frame reads
- m_axi_araddr  out  ADDR_W  burst byte address
- m_axi_arlen  out  4  BURST_LEN-1
- m_axi_arsize  out  3  constant 3'b011
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arcache  out  4  constant 4'b0011
- m_axi_arprot  out  3  constant 3'b000
- m_axi_arlock  out  1  constant 0
- m_axi_arqos  out  4  constant 0
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address ready
- m_axi_rdata  in  DATA_W  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  data valid
- m_axi_rready  out  1  data ready
- pix_data  out  24  {R,G,B}
- pix_valid  out  1  pixel valid
- pix_ready  in  1  pixel accepted
- pix_sof  out  1  first pixel of frame (qualified by pix_valid)
- pix_eol  out  1  last pixel of line (qualified by pix_valid)
- frame_done  out  1  one-cycle pulse when last pixel of frame is accepted
- rd_err  out  1  sticky error flag

Behaviour:
- Reset, asynchronous on aresetn low:
  - all outputs 0 except AR constants; state IDLE
  - address = ADDR_START; FIFO empty; pixel/column/line counters 0; rd_err = 0.
- Frame geometry:
  - beats per frame = FRAME_W*FRAME_H/2; bursts per frame = beats/BURST_LEN
  - FRAME_W*FRAME_H must be divisible by 2*BURST_LEN; the default gives 64800 bursts.
- Address step: araddr += BURST_LEN*8 (128 bytes) per burst, ADDR_W-bit arithmetic. After the last burst of a frame, the address reloads ADDR_START.
- FSM:
  - IDLE: if enable and FIFO free >= BURST_LEN -> ADDR.
  - ADDR: arvalid=1 with araddr/arlen stable until arready. On handshake -> DATA.
  - DATA: rready=1 (space was reserved). Each rvalid&rready pushes rdata into the FIFO and increments a 4-bit beat counter. On the beat with counter == BURST_LEN-1 -> NEXT.
  - NEXT: advance the address and burst counter.
    - If the frame is not finished, wait for FIFO free >= BURST_LEN, then -> ADDR. enable is ignored mid-frame; a frame always completes.
    - If the frame is finished -> IDLE. Enable is re-sampled there.
  - arvalid never deasserts before arready (AXI rule).
- Error checks; all set rd_err, which stays set until reset:
  - rresp != 00 on any beat.
  - rlast high on a beat with counter != BURST_LEN-1.
  - rlast low on the beat with counter == BURST_LEN-1.
  - The beat is stored regardless of error.
- FIFO: synchronous read/write, first-word-fall-through. Simultaneous push and pop are allowed, including push and pop on the same entry.
- Unpacker:
  - A half select alternates: pixel 0 = word[23:0], pixel 1 = word[55:32]; bits [31:24] and [63:56] are ignored.
  - pix_valid = FIFO not empty.
  - The FIFO pops when half=1 and pix_valid&pix_ready.
  - pix_data/sof/eol hold stable while pix_valid&!pix_ready.
- Markers:
  - Column counter 0..FRAME_W-1 and line counter 0..FRAME_H-1 advance on each accepted pixel.
  - pix_sof = (col==0 && line==0).
  - pix_eol = (col==FRAME_W-1).
  - frame_done pulses on acceptance of the pixel at col=FRAME_W-1, line=FRAME_H-1; both counters then wrap to 0.
- Latency: first pix_valid no earlier than 1 cycle after the first R handshake.
- Reset mid-burst: all state is discarded immediately. The interconnect must be reset with the same aresetn.

Decomposition:
- Shared package axi_frame_pkg:
  - FSM state encodings (IDLE, ADDR, DATA, NEXT)
  - AXI constants: SIZE_8B=3'b011, BURST_INCR=2'b01, CACHE_DEF=4'b0011
  - RESP_OKAY=2'b00, bytes-per-pixel = 4.
- One sub-module: frame_beat_fifo (DATA_W x FIFO_DEPTH, FWFT, outputs count/free).

Test Plan:
1. FRAME_W=16, FRAME_H=4, enable=1, slave with arready/rvalid always 1, rdata beat n = {8'h00,24'(2n+1),8'h00,24'(2n)} -> exactly 2 bursts: araddr 0x10000000 then 0x10000080, arlen=15. 64 pixels appear with values 0..63; sof on pixel 0; eol on pixels 15, 31, 47, 63; one frame_done. A third AR at 0x10000000 follows while enable stays high.
2. Same setup, pix_ready held 0 -> after one burst (32 pixels buffered, FIFO 16 beats used), a second AR issues once free >= 16. No further AR while the FIFO is full. pix_data holds pixel 0 throughout.
3. arready delayed 5 cycles -> arvalid stays 1 and araddr constant for all 5 cycles; no R beats accepted before the handshake.
4. rresp=2'b10 on beat 3 of burst 0 -> rd_err=1 from the next cycle and remains 1 through the frame; pixel stream count unaffected (64 pixels).
5. rlast asserted on beat 7 -> rd_err=1; FSM still counts 16 beats before NEXT.
6. aresetn low mid-DATA of burst 1 -> arvalid=0, pix_valid=0, rd_err=0. After release with enable=1, the first AR is at 0x10000000.
